// File: rtl/rand_num_pkg.sv
// Shared constants and the single-step Fibonacci LFSR function for rand_num.
package rand_num_pkg;

    localparam int          MAX_WIDTH    = 64;
    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // One shift-left step with XOR feedback into bit 0. The state is carried in a
    // MAX_WIDTH container, and bits at or above `width` are kept at zero.
    function automatic logic [MAX_WIDTH-1:0] lfsr_step(
        input logic [MAX_WIDTH-1:0] s,
        input logic [MAX_WIDTH-1:0] taps,
        input int unsigned          width
    );
        logic                 fb;
        logic [MAX_WIDTH-1:0] mask;
        fb   = ^(s & taps);
        mask = (width >= MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
        return {s[MAX_WIDTH-2:0], fb} & mask;
    endfunction

endpackage

// File: rtl/rand_num_lfsr_leap.sv
// Combinational leap-forward: STEPS chained LFSR steps, followed by the all-zero guard.
module lfsr_leap
    import rand_num_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS,
    parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED,
    parameter int               STEPS = 2
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] next_o
);

    logic [MAX_WIDTH-1:0] s;

    always_comb begin
        s = MAX_WIDTH'(state_i);
        for (int i = 0; i < STEPS; i++) begin
            s = lfsr_step(s, MAX_WIDTH'(TAPS), WIDTH);
        end
        next_o = s[WIDTH-1:0];
        if (next_o == '0) begin
            next_o = SEED;
        end
    end

endmodule

// File: rtl/rand_num.sv
// Free-running leap-forward LFSR random source. The optional reseed port pair is
// enabled with RAND_NUM_RESEED_EN. `rand` is a reserved word, so the output is rand_out.
module rand_num
    import rand_num_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = DEFAULT_TAPS,
    parameter logic [WIDTH-1:0] SEED      = DEFAULT_SEED,
    parameter int               OUT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef RAND_NUM_RESEED_EN
    input  logic                 seed_load,
    input  logic [WIDTH-1:0]     seed_value,
`endif
    output logic [OUT_WIDTH-1:0] rand_out
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] leap_next;

    lfsr_leap #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED),
        .STEPS (OUT_WIDTH)
    ) u_leap (
        .state_i (state_q),
        .next_o  (leap_next)
    );

    always_comb begin
        state_d = leap_next;
`ifdef RAND_NUM_RESEED_EN
        // A reseed replaces the advance; a zero seed would lock up, so it falls back to SEED.
        if (seed_load) begin
            state_d = (seed_value == '0) ? SEED : seed_value;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign rand_out = state_q[OUT_WIDTH-1:0];

endmodule

// File: tb/tb_rand_num.sv
// Directed bench for rand_num: reset value, default sequence, async reset, full period, reseed.
module tb_rand_num;

    logic        clk;
    logic        reset;
    logic [1:0]  rand_out;
`ifdef RAND_NUM_RESEED_EN
    logic        seed_load;
    logic [15:0] seed_value;
`endif

    int compared;
    int mismatched;

    rand_num dut (
        .clk        (clk),
        .reset      (reset),
`ifdef RAND_NUM_RESEED_EN
        .seed_load  (seed_load),
        .seed_value (seed_value),
`endif
        .rand_out   (rand_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        // Edges are at 5, 15, ...; assert reset at t=2 and look at t=3, before any edge.
        #2 reset = 1'b1;
        #1;
        compared++;
        if (rand_out !== 2'b01) begin
            mismatched++;
            $display("FAIL reset_rand: got %b expected 01", rand_out);
        end
        compared++;
        if (dut.state_q !== 16'hACE1) begin
            mismatched++;
            $display("FAIL reset_state: got %h expected ace1", dut.state_q);
        end
        @(posedge clk); #1;
        compared++;
        if (dut.state_q !== 16'hACE1) begin
            mismatched++;
            $display("FAIL reset_hold: got %h expected ace1", dut.state_q);
        end
    endtask

    task automatic test_sequence;
        logic [15:0] exp_state [3];
        logic [1:0]  exp_rand  [3];
        exp_state[0] = 16'hB387; exp_rand[0] = 2'b11;
        exp_state[1] = 16'hCE1E; exp_rand[1] = 2'b10;
        exp_state[2] = 16'h3879; exp_rand[2] = 2'b01;
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            compared++;
            if (dut.state_q !== exp_state[i]) begin
                mismatched++;
                $display("FAIL seq_state[%0d]: got %h expected %h", i, dut.state_q, exp_state[i]);
            end
            compared++;
            if (rand_out !== exp_rand[i]) begin
                mismatched++;
                $display("FAIL seq_rand[%0d]: got %b expected %b", i, rand_out, exp_rand[i]);
            end
        end
    endtask

    task automatic test_async_reset;
        repeat (100) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        #1;
        compared++;
        if (rand_out !== 2'b01 || dut.state_q !== 16'hACE1) begin
            mismatched++;
            $display("FAIL async_reset: got %h/%b expected ace1/01", dut.state_q, rand_out);
        end
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        compared++;
        if (dut.state_q !== 16'hB387) begin
            mismatched++;
            $display("FAIL async_restart: got %h expected b387", dut.state_q);
        end
    endtask

    task automatic test_period;
        int cnt [4];
        int zero_seen;
        int first_return;
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        zero_seen = 0;
        first_return = 0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        for (int n = 1; n <= 65535; n++) begin
            @(posedge clk); #1;
            if (dut.state_q == 16'h0000) zero_seen++;
            if (dut.state_q == 16'hACE1 && first_return == 0) first_return = n;
            cnt[rand_out]++;
        end
        compared++;
        if (dut.state_q !== 16'hACE1 || first_return != 65535) begin
            mismatched++;
            $display("FAIL period: state %h first return %0d expected ace1 at 65535",
                     dut.state_q, first_return);
        end
        compared++;
        if (zero_seen != 0) begin
            mismatched++;
            $display("FAIL period_zero: got %0d zero states expected 0", zero_seen);
        end
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (cnt[k] < 16220 || cnt[k] > 16548) begin
                mismatched++;
                $display("FAIL dist[%0d]: got %0d expected 16220..16548", k, cnt[k]);
            end
        end
    endtask

`ifdef RAND_NUM_RESEED_EN
    task automatic test_reseed;
        @(negedge clk) begin seed_load = 1'b1; seed_value = 16'h0001; end
        @(posedge clk); #1;
        compared++;
        if (dut.state_q !== 16'h0001 || rand_out !== 2'b01) begin
            mismatched++;
            $display("FAIL reseed_one: got %h/%b expected 0001/01", dut.state_q, rand_out);
        end
        @(negedge clk) seed_value = 16'h0000;
        @(posedge clk); #1;
        compared++;
        if (dut.state_q !== 16'hACE1) begin
            mismatched++;
            $display("FAIL reseed_zero: got %h expected ace1", dut.state_q);
        end
        @(negedge clk) begin seed_value = 16'h1234; reset = 1'b1; end
        @(posedge clk); #1;
        compared++;
        if (dut.state_q !== 16'hACE1) begin
            mismatched++;
            $display("FAIL reseed_vs_reset: got %h expected ace1", dut.state_q);
        end
        @(negedge clk) begin reset = 1'b0; seed_load = 1'b0; end
        @(posedge clk); #1;
        compared++;
        if (dut.state_q !== 16'hB387) begin
            mismatched++;
            $display("FAIL reseed_release: got %h expected b387", dut.state_q);
        end
    endtask
`endif

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
`ifdef RAND_NUM_RESEED_EN
        seed_load  = 1'b0;
        seed_value = 16'h0000;
`endif
        test_reset();
        test_sequence();
        test_async_reset();
        test_period();
`ifdef RAND_NUM_RESEED_EN
        test_reseed();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rand_num.md
# rand_num

Free-running pseudo-random number source for the maze carver. Holds a maximal-length Fibonacci LFSR that advances every clock and presents fresh random bits on `rand` each cycle; the carver uses the 2-bit value to choose a move direction. No handshake: consumers sample `rand` whenever they need it.

## Interface
Parameters:
- `WIDTH`, 16: LFSR state width in bits.
- `TAPS`, 16'hB400: feedback mask; a set bit i means state bit i feeds the XOR. Default is x^16+x^14+x^13+x^11+1, which uses bits 15, 13, 12 and 10.
- `SEED`, 16'hACE1: reset state; must be nonzero.
- `OUT_WIDTH`, 2: width of `rand`; also the number of LFSR steps taken per clock. Legal range 1..WIDTH.

Ports:
- `clk` input, 1 bit: sole clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `rand` output, OUT_WIDTH bits: current random value.
- `seed_load` input, 1 bit: reseed strobe. Present only with RAND_NUM_RESEED_EN.
- `seed_value` input, WIDTH bits: new seed. Present only with RAND_NUM_RESEED_EN.

## Operation
- State register `state[WIDTH-1:0]`.
- Single LFSR step: `fb = ^(s & TAPS)`, then `s' = {s[WIDTH-2:0], fb}` (shift left, feedback into bit 0).
- Each clock the state advances OUT_WIDTH chained single steps (leap-forward), so no output bit is reused between consecutive cycles.
- `rand = state[OUT_WIDTH-1:0]`, driven combinationally from the register. It is glitch-free with respect to `clk` because it depends only on flops.
- Zero-lockup guard: if the computed next state is all-zero, load SEED instead. With a nonzero SEED and maximal TAPS this is unreachable except through reseed.
- Period: 2^WIDTH−1 states. With the defaults, stepping 2 per clock, the `state` sequence repeats after exactly 65535 clocks, since gcd(2, 65535) = 1.

## Timing
- While `reset` is high: `state` = SEED asynchronously and `rand` = SEED[OUT_WIDTH-1:0] (2'b01 by default). This holds on reset assertion mid-operation too, with no clock needed.
- First rising edge after reset deassertion: `state` takes its first leap value. Latency from `state` to `rand` is 0 cycles.
- Default sequence of `state` after reset: 0xACE1 → 0xB387 → 0xCE1E, with `rand` = 01, 11, 10.
- If `reset` deasserts on the same edge as a clock, the state stays SEED for that edge; the first advance happens on the next edge.

## Configuration
- `RAND_NUM_RESEED_EN`
  - Defined: `seed_load` and `seed_value` ports exist. When `seed_load` = 1 at a rising edge, `state <= seed_value`, or SEED if `seed_value` is zero, instead of advancing. `rand` shows the new seed's low bits from that edge on. Reseed overrides the advance; `reset` overrides everything.
  - Undefined: the ports are absent and the state changes only through reset and advance.

## Structure
- Package `rand_num_pkg`: default `TAPS` and `SEED` constants, plus a pure function `lfsr_step(state, taps)` returning the next state.
- Optional sub-module `lfsr_leap`: combinational, OUT_WIDTH chained `lfsr_step` instances followed by the zero guard. It is instantiated once in `rand_num`.
- Top level holds the state register, reset/reseed priority and the output slice.

## Test plan
- Reset value: assert `reset` with no clock → `rand` = 2'b01 and `state` = 0xACE1 immediately.
- Sequence: release reset, then clock twice → `state` = 0xB387 then 0xCE1E, and `rand` = 11 then 10.
- Async reset mid-run: after 100 clocks, pulse `reset` between edges → `rand` returns to 01 before the next edge and the sequence restarts at 0xB387.
- Period: run 65535 clocks from reset → `state` = 0xACE1 again and never 0 in between. Each `rand` value 00, 01, 10 and 11 occurs within ±1% of 16384 times.
- Reseed, with RAND_NUM_RESEED_EN defined:
  - `seed_load` = 1 with `seed_value` = 0x0001 → next `state` is 0x0001 and `rand` is 01.
  - `seed_value` = 0 → `state` is 0xACE1.
  - `seed_load` and `reset` together → SEED.
- Build without RAND_NUM_RESEED_EN → only `clk`, `reset` and `rand` ports exist, and the sequence is identical to the default-sequence test.
